alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Registered WIDTH-bit combinational-function ALU with 16 operations selected by ALU_Sel.
//  Operands A/B are sampled each clk edge; the result and the carry flag are registered.
//  Sits in the processor datapath between the register-file read ports and write-back.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (all rules below are written for general WIDTH)
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  reset     in   1      synchronous, active-high reset
//  A         in   WIDTH  operand A (unsigned)
//  B         in   WIDTH  operand B (unsigned)
//  ALU_Sel   in   4      operation select
//  ALU_Out   out  WIDTH  registered result
//  CarryOut  out  1      registered carry of A+B
// BEHAVIOUR
//  - One clock, synchronous active-high reset. On a clk edge with reset=1: ALU_Out=0, CarryOut=0.
//    Reset wins over any operand/select value. Reset asserted mid-stream discards the pending result.
//  - Latency 1 cycle: ALU_Out/CarryOut after edge N reflect A, B, ALU_Sel sampled at edge N.
//    New operation accepted every cycle; no handshake, no stall.
//  - Unsigned arithmetic; results truncated to the low WIDTH bits.
//  - ALU_Sel encoding (R = next ALU_Out):
//    0 R=A+B            1 R=A-B (two's complement wrap)   2 R=A*B (low WIDTH bits)
//    3 R=A/B (integer quotient); B==0 -> R = all ones
//    4 R=A<<1 (LSB 0)   5 R=A>>1 (MSB 0)
//    6 R=rotate-left A by 1  ({A[WIDTH-2:0],A[WIDTH-1]})
//    7 R=rotate-right A by 1 ({A[0],A[WIDTH-1:1]})
//    8 A&B   9 A|B   A A^B   B ~(A|B)   C ~(A&B)   D ~(A^B)
//    E R = (A>B) ? 1 : 0 (zero-extended)     F R = (A==B) ? 1 : 0 (zero-extended)
//  - CarryOut = bit WIDTH of {1'b0,A}+{1'b0,B}, computed every cycle independent of ALU_Sel.
//  - All 16 codes are defined; there is no illegal select. No X propagation from defined inputs.
//  - Outputs are held (not changed) between edges; no internal state besides the output registers.
// TESTING
//  - reset=1 for 2 cycles with A=FF,B=FF,Sel=0 -> ALU_Out=00, CarryOut=0; deassert -> next edge ALU_Out=FE, CarryOut=1.
//  - A=0A,B=02, sweep Sel 1..F then 0 (one per cycle) -> 08,14,05,14,05,14,05,02,0A,08,F5,FD,F7,01,00,0C; CarryOut=0 throughout.
//  - A=F6,B=0A: Sel=0 -> 00, CarryOut=1; Sel=1 -> EC; Sel=E -> 01; Sel=F -> 00.
//  - Boundary: A=81: Sel=6 -> 03, Sel=7 -> C0, Sel=4 -> 02, Sel=5 -> 40; A=05,B=00 Sel=3 -> FF; A=B=3C Sel=F -> 01, Sel=E -> 00.
//  - Wrap: A=00,B=01 Sel=1 -> FF; A=10,B=10 Sel=2 -> 00 (low byte of 0x100).
//  - Reset mid-stream: pulse reset 1 cycle during sweep -> that cycle output 00/0, next cycle resumes correct result for current inputs.

Source files
------------

// File: rtl/alu.sv
// Registered WIDTH-bit ALU: 16 operations picked by ALU_Sel, one-cycle latency.
// Carry of A+B is registered every cycle regardless of the selected operation.
module alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_Sel,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             CarryOut
);

   logic [WIDTH-1:0] alu_out_d, alu_out_q;
   logic             carry_d, carry_q;
   logic [WIDTH:0]   sum;

   always_comb begin
      sum       = {1'b0, A} + {1'b0, B};
      carry_d   = sum[WIDTH];
      alu_out_d = '0;
      case (ALU_Sel)
         4'h0: alu_out_d = sum[WIDTH-1:0];
         4'h1: alu_out_d = A - B;
         4'h2: alu_out_d = A * B;
         // Divide-by-zero saturates to all ones instead of being undefined
         4'h3: alu_out_d = (B == '0) ? '1 : A / B;
         4'h4: alu_out_d = {A[WIDTH-2:0], 1'b0};
         4'h5: alu_out_d = {1'b0, A[WIDTH-1:1]};
         4'h6: alu_out_d = {A[WIDTH-2:0], A[WIDTH-1]};
         4'h7: alu_out_d = {A[0], A[WIDTH-1:1]};
         4'h8: alu_out_d = A & B;
         4'h9: alu_out_d = A | B;
         4'hA: alu_out_d = A ^ B;
         4'hB: alu_out_d = ~(A | B);
         4'hC: alu_out_d = ~(A & B);
         4'hD: alu_out_d = ~(A ^ B);
         4'hE: alu_out_d = {{(WIDTH-1){1'b0}}, (A > B)};
         4'hF: alu_out_d = {{(WIDTH-1){1'b0}}, (A == B)};
         default: alu_out_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_out_q <= '0;
         carry_q   <= 1'b0;
      end else begin
         alu_out_q <= alu_out_d;
         carry_q   <= carry_d;
      end
   end

   assign ALU_Out  = alu_out_q;
   assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases with fixed expectations, then
// random operands checked against an integer-arithmetic reference model.
module tb_alu;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] A, B;
   logic [3:0]   ALU_Sel;
   logic [W-1:0] ALU_Out;
   logic         CarryOut;

   int passes = 0;
   int total  = 0;

   alu #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .ALU_Sel(ALU_Sel),
      .ALU_Out(ALU_Out), .CarryOut(CarryOut)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, masked down to W bits.
   function automatic logic [W:0] model(input int a, input int b, input int sel);
      int m, r;
      m = (1 << W) - 1;
      case (sel)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a * b;
         3:  r = (b == 0) ? m : a / b;
         4:  r = a * 2;
         5:  r = a / 2;
         6:  r = (a * 2) + (a / (1 << (W-1)));
         7:  r = (a / 2) + ((a % 2) << (W-1));
         8:  r = a & b;
         9:  r = a | b;
         10: r = a ^ b;
         11: r = ~(a | b);
         12: r = ~(a & b);
         13: r = ~(a ^ b);
         14: r = (a > b) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      model = {((a + b) > m) ? 1'b1 : 1'b0, W'(r & m)};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] eo, input logic ec);
      total++;
      assert (ALU_Out === eo) passes++;
      else $error("FAIL %s out: got %h expected %h", tag, ALU_Out, eo);
      total++;
      assert (CarryOut === ec) passes++;
      else $error("FAIL %s carry: got %b expected %b", tag, CarryOut, ec);
   endtask

   // Apply inputs away from the edge, clock once, sample 1 time unit later.
   task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s);
      @(negedge clk);
      reset = r; A = a; B = b; ALU_Sel = s;
      @(posedge clk);
      #1;
   endtask

   task automatic dstep(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic [W-1:0] eo, input logic ec);
      step(1'b0, a, b, s);
      check(tag, eo, ec);
   endtask

   logic [W-1:0] sweep_exp [16] = '{8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                                    8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01,
                                    8'h00, 8'h0C};

   initial begin
      logic [W:0] e;
      logic [W-1:0] ra, rb;
      logic [3:0] rs;

      // Reset dominates live operands
      step(1'b1, 8'hFF, 8'hFF, 4'h0); check("rst1", 8'h00, 1'b0);
      step(1'b1, 8'hFF, 8'hFF, 4'h0); check("rst2", 8'h00, 1'b0);
      dstep("post_rst", 8'hFF, 8'hFF, 4'h0, 8'hFE, 1'b1);

      for (int i = 0; i < 16; i++)
         dstep($sformatf("sweep_sel%0h", (i + 1) % 16), 8'h0A, 8'h02, 4'((i + 1) % 16),
               sweep_exp[i], 1'b0);

      dstep("f6_add", 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1);
      dstep("f6_sub", 8'hF6, 8'h0A, 4'h1, 8'hEC, 1'b1);
      dstep("f6_gt",  8'hF6, 8'h0A, 4'hE, 8'h01, 1'b1);
      dstep("f6_eq",  8'hF6, 8'h0A, 4'hF, 8'h00, 1'b1);

      dstep("rol81",  8'h81, 8'h00, 4'h6, 8'h03, 1'b0);
      dstep("ror81",  8'h81, 8'h00, 4'h7, 8'hC0, 1'b0);
      dstep("shl81",  8'h81, 8'h00, 4'h4, 8'h02, 1'b0);
      dstep("shr81",  8'h81, 8'h00, 4'h5, 8'h40, 1'b0);
      dstep("div0",   8'h05, 8'h00, 4'h3, 8'hFF, 1'b0);
      dstep("eq3c",   8'h3C, 8'h3C, 4'hF, 8'h01, 1'b0);
      dstep("gt3c",   8'h3C, 8'h3C, 4'hE, 8'h00, 1'b0);
      dstep("subwrap", 8'h00, 8'h01, 4'h1, 8'hFF, 1'b0);
      dstep("mulwrap", 8'h10, 8'h10, 4'h2, 8'h00, 1'b0);

      // Reset pulse mid-sweep discards that cycle, then normal results resume
      dstep("mid_a", 8'h0A, 8'h02, 4'h1, 8'h08, 1'b0);
      step(1'b1, 8'h0A, 8'h02, 4'h2); check("mid_rst", 8'h00, 1'b0);
      dstep("mid_b", 8'h0A, 8'h02, 4'h3, 8'h05, 1'b0);

      // Outputs hold between edges
      @(negedge clk);
      check("hold", 8'h05, 1'b0);

      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom);
         rb = (i % 17 == 0) ? '0 : W'($urandom);
         if (i % 23 == 0) rb = ra;
         rs = 4'($urandom);
         step(1'b0, ra, rb, rs);
         e = model(int'(ra), int'(rb), int'(rs));
         check($sformatf("rnd%0d_a%h_b%h_s%h", i, ra, rb, rs), e[W-1:0], e[W]);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
